// File: rtl/bsg_circular_ptr_slot_tracker_p32.sv
// Circular-buffer slot tracker: owns the read and write pointers and the occupancy count,
// and grants bulk allocations only when the buffer has enough free slots.
module bsg_circular_ptr_slot_tracker_p32 #(
  parameter int unsigned slots_p   = 32,
  parameter int unsigned max_add_p = 31
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       alloc_v_i,
  input  logic [4:0] alloc_cnt_i,
  output logic       alloc_yumi_o,
  output logic [4:0] alloc_ptr_o,
  input  logic       free_v_i,
  input  logic [4:0] free_cnt_i,
  output logic [4:0] rd_ptr_o,
  output logic [4:0] wr_ptr_o,
  output logic [5:0] count_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       err_o
);

  localparam int unsigned ptr_width_lp = $clog2(slots_p);
  localparam int unsigned cnt_width_lp = $clog2(slots_p + 1);
  localparam int unsigned add_width_lp = $clog2(max_add_p + 1);

  logic [ptr_width_lp-1:0] wr_ptr_r, wr_ptr_n;
  logic [ptr_width_lp-1:0] rd_ptr_r, rd_ptr_n;
  logic [cnt_width_lp-1:0] count_r, count_n;
  logic                    err_r, err_n;

  logic [cnt_width_lp-1:0] free_slots;
  logic [cnt_width_lp-1:0] alloc_amt;
  logic [cnt_width_lp-1:0] free_amt;
  logic                    alloc_fits;
  logic                    free_ok;

  // Space is judged on registered count only, so a same-cycle release never funds an alloc.
  assign alloc_amt    = cnt_width_lp'(alloc_cnt_i);
  assign free_amt     = cnt_width_lp'(free_cnt_i);
  assign free_slots   = cnt_width_lp'(slots_p) - count_r;
  assign alloc_fits   = (alloc_amt <= free_slots);
  assign alloc_yumi_o = alloc_v_i & alloc_fits & reset_n_i;
  assign free_ok      = free_v_i & (free_amt <= count_r);

  // Next-state: independent pointer advances, net occupancy change, sticky over-release flag.
  always_comb begin
    wr_ptr_n = wr_ptr_r;
    rd_ptr_n = rd_ptr_r;
    count_n  = count_r;
    err_n    = err_r;
    if (alloc_yumi_o) begin
      wr_ptr_n = wr_ptr_r + ptr_width_lp'(alloc_cnt_i);
    end
    if (free_ok) begin
      rd_ptr_n = rd_ptr_r + ptr_width_lp'(free_cnt_i);
    end
    count_n = count_r + (alloc_yumi_o ? alloc_amt : '0) - (free_ok ? free_amt : '0);
    if (free_v_i && !free_ok) begin
      err_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_n;
      rd_ptr_r <= rd_ptr_n;
      count_r  <= count_n;
      err_r    <= err_n;
    end
  end

  assign alloc_ptr_o = wr_ptr_r;
  assign wr_ptr_o    = wr_ptr_r;
  assign rd_ptr_o    = rd_ptr_r;
  assign count_o     = count_r;
  assign empty_o     = (count_r == '0);
  assign full_o      = (count_r == cnt_width_lp'(slots_p));
  assign err_o       = err_r;

  wire unused_add_width = (add_width_lp == ptr_width_lp);

endmodule

// File: tb/tb_bsg_circular_ptr_slot_tracker_p32.sv
// Bench for the circular slot tracker: directed scenarios plus random traffic,
// all checked against an integer occupancy model.
module tb_bsg_circular_ptr_slot_tracker_p32;

  logic       clk;
  logic       reset_n_i;
  logic       alloc_v_i;
  logic [4:0] alloc_cnt_i;
  logic       alloc_yumi_o;
  logic [4:0] alloc_ptr_o;
  logic       free_v_i;
  logic [4:0] free_cnt_i;
  logic [4:0] rd_ptr_o;
  logic [4:0] wr_ptr_o;
  logic [5:0] count_o;
  logic       empty_o;
  logic       full_o;
  logic       err_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integers, pointers kept modulo 32.
  int m_wr  = 0;
  int m_rd  = 0;
  int m_cnt = 0;
  int m_err = 0;

  bsg_circular_ptr_slot_tracker_p32 dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .alloc_v_i    (alloc_v_i),
    .alloc_cnt_i  (alloc_cnt_i),
    .alloc_yumi_o (alloc_yumi_o),
    .alloc_ptr_o  (alloc_ptr_o),
    .free_v_i     (free_v_i),
    .free_cnt_i   (free_cnt_i),
    .rd_ptr_o     (rd_ptr_o),
    .wr_ptr_o     (wr_ptr_o),
    .count_o      (count_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .err_o        (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".wr_ptr"}, 32'(wr_ptr_o), 32'(m_wr));
    check({tag, ".rd_ptr"}, 32'(rd_ptr_o), 32'(m_rd));
    check({tag, ".count"},  32'(count_o),  32'(m_cnt));
    check({tag, ".empty"},  32'(empty_o),  32'(m_cnt == 0));
    check({tag, ".full"},   32'(full_o),   32'(m_cnt == 32));
    check({tag, ".err"},    32'(err_o),    32'(m_err));
  endtask

  task automatic model_reset();
    m_wr  = 0;
    m_rd  = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  // One cycle of traffic, entered and left at a falling edge.
  task automatic step(input string tag, input bit av, input int ac, input bit fv, input int fc);
    bit exp_yumi;
    bit exp_fok;
    alloc_v_i   = av;
    alloc_cnt_i = 5'(ac);
    free_v_i    = fv;
    free_cnt_i  = 5'(fc);
    #1;
    exp_yumi = av && (ac <= 32 - m_cnt);
    exp_fok  = fv && (fc <= m_cnt);
    check({tag, ".yumi"},      32'(alloc_yumi_o), 32'(exp_yumi));
    check({tag, ".alloc_ptr"}, 32'(alloc_ptr_o),  32'(m_wr));
    @(posedge clk);
    if (exp_yumi) begin
      m_wr  = (m_wr + ac) % 32;
      m_cnt = m_cnt + ac;
    end
    if (exp_fok) begin
      m_rd  = (m_rd + fc) % 32;
      m_cnt = m_cnt - fc;
    end
    if (fv && !exp_fok) m_err = 1;
    @(negedge clk);
    alloc_v_i = 1'b0;
    free_v_i  = 1'b0;
    check_state(tag);
  endtask

  // Reset asserted between clock edges; state must clear without any edge.
  task automatic mid_reset(input string tag);
    alloc_v_i   = 1'b1;
    alloc_cnt_i = 5'd1;
    #2;
    reset_n_i = 1'b0;
    #1;
    model_reset();
    check({tag, ".yumi"}, 32'(alloc_yumi_o), 32'd0);
    check({tag, ".alloc_ptr"}, 32'(alloc_ptr_o), 32'd0);
    check_state(tag);
    alloc_v_i = 1'b0;
    @(negedge clk);
    reset_n_i = 1'b1;
  endtask

  initial begin
    bit av, fv;
    int ac, fc;
    reset_n_i   = 1'b0;
    alloc_v_i   = 1'b1;
    alloc_cnt_i = 5'd3;
    free_v_i    = 1'b0;
    free_cnt_i  = 5'd0;
    repeat (2) @(negedge clk);
    check("rst.yumi", 32'(alloc_yumi_o), 32'd0);
    check_state("rst");
    alloc_v_i = 1'b0;
    reset_n_i = 1'b1;
    @(negedge clk);
    check_state("idle");

    // Fill exactly to 32, then a further alloc must stall.
    step("fill31", 1, 31, 0, 0);
    step("fill1",  1, 1,  0, 0);
    check("full.flag", 32'(full_o), 32'd1);
    step("stall_a", 1, 1, 0, 0);
    step("stall_b", 1, 1, 0, 0);
    step("alloc0_full", 1, 0, 0, 0);

    // Drain and move wr_ptr to 28, then a wrapping alloc of 7.
    step("drain31", 0, 0, 1, 31);
    step("drain1",  0, 0, 1, 1);
    step("adv28",   1, 28, 0, 0);
    step("rel28",   0, 0, 1, 28);
    step("wrap7",   1, 7, 0, 0);
    check("wrap.wr", 32'(wr_ptr_o), 32'd3);
    step("free7",   0, 0, 1, 7);
    check("wrap.rd", 32'(rd_ptr_o), 32'd3);

    // Simultaneous alloc and free when full: free goes, alloc waits one cycle.
    step("refill31", 1, 31, 0, 0);
    step("refill1",  1, 1,  0, 0);
    step("both4",    1, 4, 1, 4);
    check("both4.cnt", 32'(count_o), 32'd28);
    step("retry4",   1, 4, 0, 0);
    check("retry4.cnt", 32'(count_o), 32'd32);

    // Over-release is ignored and latches the sticky error.
    step("to5",    0, 0, 1, 27);
    step("over6",  0, 0, 1, 6);
    check("over6.cnt", 32'(count_o), 32'd5);
    step("idle_err", 0, 0, 0, 0);
    check("err.sticky", 32'(err_o), 32'd1);

    // Reset in the middle of a cycle at count 17.
    step("to17", 1, 12, 0, 0);
    check("to17.cnt", 32'(count_o), 32'd17);
    mid_reset("mid_rst");
    step("post_rst", 1, 2, 0, 0);

    // Random traffic with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      av = ($urandom_range(0, 3) != 0);
      ac = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8);
      fv = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) fc = $urandom_range(0, 31);
      else fc = $urandom_range(0, (m_cnt < 31) ? m_cnt : 31);
      step("rnd", av, ac, fv, fc);
      if ((i % 500) == 499) mid_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_circular_ptr_slot_tracker_p32.md
Name: bsg_circular_ptr_slot_tracker_p32

Overview:
Bulk allocator/releaser for a 32-entry circular buffer. It owns the write pointer and read pointer, each a modulo-32 circular pointer advanced by a variable amount per cycle. It tracks occupancy and grants multi-slot allocations only when enough slots are free. It sits directly upstream of the buffer's data array and supplies the add amounts and base pointers that the array's pointer logic consumes.

Parameters:
slots_p, 32, number of slots; power of two
max_add_p, 31, largest alloc or free count in one cycle
ptr_width_lp, 5, log2(slots_p); derived, not overridable
cnt_width_lp, 6, log2(slots_p+1); derived, not overridable

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n_i  in  1  asynchronous, active-low reset
alloc_v_i  in  1  allocation request valid
alloc_cnt_i  in  5  slots requested (0..31)
alloc_yumi_o  out  1  request accepted this cycle (combinational)
alloc_ptr_o  out  5  base slot of accepted allocation (= wr_ptr before update)
free_v_i  in  1  release valid
free_cnt_i  in  5  slots released, oldest first (0..31)
rd_ptr_o  out  5  oldest occupied slot
wr_ptr_o  out  5  next slot to allocate
count_o  out  6  occupied slots (0..32)
empty_o  out  1  count_o == 0
full_o  out  1  count_o == 32
err_o  out  1  sticky over-release error

Behaviour:
- Reset (asynchronous, reset_n_i low): wr_ptr=0, rd_ptr=0, count=0, err=0. Outputs: empty_o=1, full_o=0, alloc_yumi_o=0, alloc_ptr_o=0. Reset may assert mid-operation. All state clears immediately, and the in-flight request is dropped.
- free_slots = 32 - count. It is computed from registered count only; a same-cycle release does not make room for a same-cycle alloc.
- alloc_yumi_o = alloc_v_i & (alloc_cnt_i <= free_slots) & reset_n_i. This is zero-latency and combinational from inputs and state.
- On alloc_yumi_o: wr_ptr <= (wr_ptr + alloc_cnt_i) mod 32. alloc_ptr_o = wr_ptr at all times, so it is valid with yumi.
- Rejected alloc: no state change. The requester holds alloc_v_i and alloc_cnt_i until yumi; cnt changes while waiting are allowed but not required.
- alloc_cnt_i == 0 with alloc_v_i: yumi=1 (including when full), no state change.
- free accepted when free_v_i & (free_cnt_i <= count). On accept: rd_ptr <= (rd_ptr + free_cnt_i) mod 32.
- Over-release (free_v_i & free_cnt_i > count): ignored entirely, err <= 1. err clears only on reset.
- count_n = count + (yumi ? alloc_cnt_i : 0) - (free accepted ? free_cnt_i : 0), in 6-bit arithmetic. The result never exceeds 32 or goes below 0 by construction.
- Invariant: (wr_ptr - rd_ptr) mod 32 == count mod 32. With count==32, wr_ptr==rd_ptr and full_o=1; with count==0, also wr_ptr==rd_ptr and empty_o=1.
- Pointer addition is 5-bit wrapping with no saturation; carry out is discarded.
- full_o and empty_o are decoded from registered count with no extra latency.

Test Plan:
- Reset then idle -> count_o=0, empty_o=1, full_o=0, rd_ptr_o=wr_ptr_o=0, err_o=0.
- Alloc 31, then alloc 1 -> yumi both cycles, alloc_ptr_o=0 then 31. After the second, count_o=32, full_o=1, wr_ptr_o=0. Alloc 1 then -> yumi=0 held until free.
- From wr_ptr=28, count=0: alloc 7 -> alloc_ptr_o=28, wr_ptr_o=3 (wrap), count_o=7. Free 7 -> rd_ptr_o=3, empty_o=1.
- count=32, simultaneous alloc 4 and free 4 -> alloc rejected (yumi=0), free accepted, count_o=28. Next cycle the alloc is accepted and count_o=32.
- count=5, free 6 -> ignored, count_o stays 5, err_o=1 and remains set. Alloc 0 while full -> yumi=1, no change.
- Reset_n_i pulsed low mid-cycle at count=17 -> outputs immediately return to reset values without a clock edge.
